bus_cycle_controller: RTL and testbench



---
 rtl/bus_cycle_pkg.sv | 20 ++
 rtl/bus_cycle_if.sv | 28 ++
 rtl/bus_sync.sv | 21 ++
 rtl/bus_cycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller.
// The HOLD state exists only when BUS_STEP_EN is defined.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_ERROR
`ifdef BUS_STEP_EN
    , S_HOLD
`endif
  } state_t;

  localparam logic [2:0] FC_IACK    = 3'b111;
  localparam int         WAIT_W_DEF = 4;
  localparam int         ERR_CNT_W  = 8;

endpackage

// File: rtl/bus_cycle_if.sv
// CPU-side strobes in, chip-select / termination signals out.
interface bus_cycle_if #(
  parameter int ADDR_W = 24,
  parameter int NUM_CS = 4
);
  logic                            AS_IN;
  logic                            WR_IN;
  logic                            UDS_IN;
  logic                            LDS_IN;
  logic [2:0]                      STATUS_CODE_IN;
  logic [ADDR_W-1:0]               ADDR_IN;
  logic [NUM_CS-1:0]               CS;
  logic                            OUTPUT_ENABLE;
  logic                            DATA_ACK;
  logic                            INT_AUTOVEC_ACK;
  logic                            BUS_ERROR;
  logic [bus_cycle_pkg::ERR_CNT_W-1:0] ERROR_COUNT;

  modport master (
    output AS_IN, WR_IN, UDS_IN, LDS_IN, STATUS_CODE_IN, ADDR_IN,
    input  CS, OUTPUT_ENABLE, DATA_ACK, INT_AUTOVEC_ACK, BUS_ERROR, ERROR_COUNT
  );

  modport slave (
    input  AS_IN, WR_IN, UDS_IN, LDS_IN, STATUS_CODE_IN, ADDR_IN,
    output CS, OUTPUT_ENABLE, DATA_ACK, INT_AUTOVEC_ACK, BUS_ERROR, ERROR_COUNT
  );
endinterface

// File: rtl/bus_sync.sv
// Parametrised-width 2-flop synchronizer, async active-low reset to 0.
module bus_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/bus_cycle_controller.sv
// 68000 bus-cycle controller: window decode, wait states, DTACK/AVEC/BERR.
// Optional single-step HOLD state and STEP_EN_IN/STEP_IN ports under BUS_STEP_EN.
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int                       ADDR_W      = 24,
  parameter int                       NUM_CS      = 4,
  parameter int                       WAIT_W      = WAIT_W_DEF,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE     = '0,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK     = '0,
  parameter logic [NUM_CS*WAIT_W-1:0] CS_WAIT     = '0,
  parameter logic [NUM_CS-1:0]        CS_WRITABLE = '1,
  parameter int                       TIMEOUT     = 64
) (
  input logic        MCLK_IN,
  input logic        RESET_n_IN,
  bus_cycle_if.slave bus
`ifdef BUS_STEP_EN
  ,
  input logic        STEP_EN_IN,
  input logic        STEP_IN
`endif
);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

  logic [3:0] strb_s;
  logic       as_s, wr_s, uds_s, lds_s, as_prev, as_rise;

  bus_sync #(.W(4)) u_strb_sync (
    .clk   (MCLK_IN),
    .rst_n (RESET_n_IN),
    .d     ({bus.AS_IN, bus.WR_IN, bus.UDS_IN, bus.LDS_IN}),
    .q     (strb_s)
  );
  assign {as_s, wr_s, uds_s, lds_s} = strb_s;
  assign as_rise = as_s & ~as_prev;

  state_t            state, state_n, done_st;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        fc_q;
  logic              wr_q, mapped_q, mapped_n, iack_q, iack_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_CS-1:0] sel_q, sel_n;

  logic [NUM_CS-1:0]    cs_q, cs_d;
  logic                 oe_q, oe_d, dtack_q, dtack_d, avec_q, avec_d, berr_q, berr_d;
  logic [ERR_CNT_W-1:0] err_cnt;

`ifdef BUS_STEP_EN
  logic [1:0] step_s;
  logic       step_prev, step_rise;

  bus_sync #(.W(2)) u_step_sync (
    .clk   (MCLK_IN),
    .rst_n (RESET_n_IN),
    .d     ({STEP_EN_IN, STEP_IN}),
    .q     (step_s)
  );
  assign step_rise = step_s[0] & ~step_prev;
  assign done_st   = step_s[1] ? S_HOLD : S_ACK;

  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) step_prev <= 1'b0;
    else             step_prev <= step_s[0];
  end
`else
  assign done_st = S_ACK;
`endif

  // Lowest-index matching window wins.
  logic [NUM_CS-1:0] hit_oh;
  logic              hit, hit_wr;
  logic [WAIT_W-1:0] hit_wait;

  always_comb begin
    hit_oh   = '0;
    hit      = 1'b0;
    hit_wr   = 1'b0;
    hit_wait = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!hit && ((addr_q & CS_MASK[i*ADDR_W +: ADDR_W]) ==
                   (CS_BASE[i*ADDR_W +: ADDR_W] & CS_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
        hit_wr    = CS_WRITABLE[i];
        hit_wait  = CS_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel_q;
    mapped_n = mapped_q;
    iack_n   = iack_q;
    case (state)
      S_IDLE: begin
        sel_n = '0;
        if (as_rise) state_n = S_DECODE;
      end
      S_DECODE: begin
        iack_n   = (fc_q == FC_IACK);
        mapped_n = hit;
        sel_n    = '0;
        if (!as_s) begin
          state_n = S_IDLE;
        end else if (fc_q == FC_IACK) begin
          state_n = done_st;
        end else if (hit) begin
          if (wr_q && !hit_wr) begin
            state_n = S_ERROR;
          end else begin
            sel_n = hit_oh;
            if (hit_wait == '0) begin
              state_n = done_st;
            end else begin
              state_n = S_WAIT;
              cnt_n   = CNT_W'(hit_wait);
            end
          end
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(TIMEOUT - 1);
        end
      end
      S_WAIT: begin
        if (!as_s)                    state_n = S_IDLE;
        else if (cnt == CNT_W'(1))    state_n = mapped_q ? done_st : S_ERROR;
        else                          cnt_n   = cnt - 1'b1;
      end
      S_ACK, S_ERROR: begin
        if (!as_s) state_n = S_IDLE;
      end
`ifdef BUS_STEP_EN
      S_HOLD: begin
        if (!as_s)          state_n = S_IDLE;
        else if (step_rise) state_n = S_ACK;
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cs_d = '0;
    if (state_n == S_WAIT || state_n == S_ACK
`ifdef BUS_STEP_EN
        || state_n == S_HOLD
`endif
       ) cs_d = sel_n;
    oe_d    = (|cs_d) & ~wr_s & (uds_s | lds_s);
    dtack_d = (state_n == S_ACK) & ~iack_n;
    avec_d  = (state_n == S_ACK) &  iack_n;
    berr_d  = (state_n == S_ERROR);
  end

  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      state    <= S_IDLE;
      as_prev  <= 1'b0;
      addr_q   <= '0;
      fc_q     <= '0;
      wr_q     <= 1'b0;
      cnt      <= '0;
      sel_q    <= '0;
      mapped_q <= 1'b0;
      iack_q   <= 1'b0;
      cs_q     <= '0;
      oe_q     <= 1'b0;
      dtack_q  <= 1'b0;
      avec_q   <= 1'b0;
      berr_q   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      as_prev  <= as_s;
      cnt      <= cnt_n;
      sel_q    <= sel_n;
      mapped_q <= mapped_n;
      iack_q   <= iack_n;
      // Address/FC are stable by the time synced AS rises, so no sync needed.
      if (state == S_IDLE && as_rise) begin
        addr_q <= bus.ADDR_IN;
        fc_q   <= bus.STATUS_CODE_IN;
        wr_q   <= wr_s;
      end
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      dtack_q <= dtack_d;
      avec_q  <= avec_d;
      berr_q  <= berr_d;
      if (state_n == S_ERROR && state != S_ERROR && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.CS              = cs_q;
  assign bus.OUTPUT_ENABLE   = oe_q;
  assign bus.DATA_ACK        = dtack_q;
  assign bus.INT_AUTOVEC_ACK = avec_q;
  assign bus.BUS_ERROR       = berr_q;
  assign bus.ERROR_COUNT     = err_cnt;
endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: vector table + scoreboard, plus corner sequences.
module tb_bus_cycle_controller;
  import bus_cycle_pkg::*;

  localparam int ADDR_W  = 24;
  localparam int NUM_CS  = 4;
  localparam int WAIT_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int K_ACK = 0, K_AVEC = 1, K_BERR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_cycle_if #(.ADDR_W(ADDR_W), .NUM_CS(NUM_CS)) bif ();
`ifdef BUS_STEP_EN
  logic step_en = 1'b0;
  logic step = 1'b0;
`endif

  bus_cycle_controller #(
    .ADDR_W      (ADDR_W),
    .NUM_CS      (NUM_CS),
    .WAIT_W      (WAIT_W),
    .CS_BASE     ({24'h200000, 24'h100000, 24'h080000, 24'h000000}),
    .CS_MASK     ({24'hFF0000, 24'hF80000, 24'hF80000, 24'hF80000}),
    .CS_WAIT     ({4'd2, 4'd1, 4'd3, 4'd0}),
    .CS_WRITABLE (4'b1110),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .MCLK_IN    (clk),
    .RESET_n_IN (rst_n),
    .bus        (bif)
`ifdef BUS_STEP_EN
    ,
    .STEP_EN_IN (step_en),
    .STEP_IN    (step)
`endif
  );

  typedef struct {
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        wr;
    logic [3:0]  cs;
    logic        oe;
    int          kind;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bif.CS != 4'b0, bif.OUTPUT_ENABLE, bif.DATA_ACK, bif.INT_AUTOVEC_ACK, bif.BUS_ERROR};
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    bif.ADDR_IN        = v.addr;
    bif.STATUS_CODE_IN = v.fc;
    bif.WR_IN          = v.wr;
    bif.UDS_IN         = 1'b1;
    bif.LDS_IN         = 1'b1;
    bif.AS_IN          = 1'b1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    bif.AS_IN  = 1'b0;
    bif.UDS_IN = 1'b0;
    bif.LDS_IN = 1'b0;
    bif.WR_IN  = 1'b0;
  endtask

  // Edge 0 is the first posedge after drive(); lat is the edge index after
  // which a terminator is first seen.
  task automatic run_cycle(input vec_t v);
    int lat;
    logic [3:0] cs_seen, cs3;
    logic oe3;
    logic [2:0] term;
    vec_t e;
    lat = -1; cs_seen = '0; cs3 = '0; oe3 = 1'b0; term = '0;
    drive(v);
    sb.push_back(v);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      cs_seen |= bif.CS;
      if (k == 3) begin
        cs3 = bif.CS;
        oe3 = bif.OUTPUT_ENABLE;
      end
      if (bif.DATA_ACK || bif.INT_AUTOVEC_ACK || bif.BUS_ERROR) begin
        lat  = k;
        term = {bif.BUS_ERROR, bif.INT_AUTOVEC_ACK, bif.DATA_ACK};
        break;
      end
    end
    e = sb.pop_front();
    if (e.kind == K_BERR && exp_errs < 255) exp_errs++;
    chk("latency", 32'(lat), 32'(e.lat));
    chk("term_kind", 32'(term), 32'(3'b001 << e.kind));
    chk("cs_at_edge3", 32'(cs3), 32'(e.cs));
    chk("oe_at_edge3", 32'(oe3), 32'(e.oe));
    chk("cs_seen", 32'(cs_seen), 32'(e.cs));
    chk("error_count", 32'(bif.ERROR_COUNT), 32'(exp_errs));
    release_bus();
    repeat (4) @(posedge clk);
    #1 chk("outs_after_as_drop", 32'(outs()), 32'd0);
  endtask

  initial begin
    logic seen;
    int k;
    bif.AS_IN = 0; bif.WR_IN = 0; bif.UDS_IN = 0; bif.LDS_IN = 0;
    bif.STATUS_CODE_IN = 0; bif.ADDR_IN = 0;

    vecs[0] = '{24'h080010, 3'b101, 1'b0, 4'b0010, 1'b1, K_ACK,  6};
    vecs[1] = '{24'h000100, 3'b110, 1'b0, 4'b0001, 1'b1, K_ACK,  3};
    vecs[2] = '{24'hFFFFF0, 3'b111, 1'b0, 4'b0000, 1'b0, K_AVEC, 3};
    vecs[3] = '{24'h000200, 3'b101, 1'b1, 4'b0000, 1'b0, K_BERR, 3};
    vecs[4] = '{24'hF00000, 3'b101, 1'b0, 4'b0000, 1'b0, K_BERR, TIMEOUT + 2};
    vecs[5] = '{24'h080020, 3'b101, 1'b1, 4'b0010, 1'b0, K_ACK,  6};
    vecs[6] = '{24'h100000, 3'b101, 1'b0, 4'b0100, 1'b1, K_ACK,  4};
    vecs[7] = '{24'h200004, 3'b101, 1'b1, 4'b1000, 1'b0, K_ACK,  5};

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_errcnt", 32'(bif.ERROR_COUNT), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_outs", 32'(outs()), 32'd0);

    foreach (vecs[i]) run_cycle(vecs[i]);

    // Abort during the unmapped WAIT: no BERR, no count change
    drive(vecs[4]);
    repeat (8) @(posedge clk);
    release_bus();
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen |= bif.BUS_ERROR;
    end
    chk("abort_no_berr", 32'(seen), 32'd0);
    chk("abort_errcnt", 32'(bif.ERROR_COUNT), 32'(exp_errs));
    chk("abort_outs", 32'(outs()), 32'd0);

    // Saturate the error counter
    repeat (260) run_cycle(vecs[3]);
    chk("errcnt_saturated", 32'(bif.ERROR_COUNT), 32'd255);

    // Asynchronous reset in the middle of ACK
    drive(vecs[0]);
    k = 0;
    while (!bif.DATA_ACK && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dtack_before_reset", 32'(bif.DATA_ACK), 32'd1);
    #2;
    rst_n = 1'b0;
    bif.AS_IN = 1'b0; bif.UDS_IN = 1'b0; bif.LDS_IN = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    chk("async_reset_errcnt", 32'(bif.ERROR_COUNT), 32'd0);
    exp_errs = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_cycle(vecs[1]);
    run_cycle(vecs[3]);

`ifdef BUS_STEP_EN
    // Single-step: DATA_ACK waits for a STEP_IN rise
    @(negedge clk) step_en = 1'b1;
    repeat (3) @(posedge clk);
    drive(vecs[0]);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen |= bif.DATA_ACK;
    end
    chk("step_no_dtack", 32'(seen), 32'd0);
    chk("step_cs_held", 32'(bif.CS), 32'(4'b0010));
    @(negedge clk) step = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("step_dtack_early", 32'(bif.DATA_ACK), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("step_dtack", 32'(bif.DATA_ACK), 32'd1);
    @(negedge clk) step = 1'b0;
    release_bus();
    repeat (4) @(posedge clk);
    #1 chk("step_release", 32'(outs()), 32'd0);
    @(negedge clk) step_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
